struct_nibble_deframer: RTL and testbench
=========================================

// Module: struct_nibble_deframer
// PURPOSE
// - Rebuilds the packed frame struct {t, x[5:2], sy.y[2:7][3:0], sz.z[7:2][2:9][1:4]} from a 4-bit beat stream.
// - Sits directly upstream of the struct consumers (dimension/size checkers, field decoders).
// - Output is the whole struct, 221 bits at default parameters, released with a valid/ready handshake.
// - Double-buffered: the next frame assembles while the previous one is held at the output.
// PARAMETERS
// - NIB_W    4  beat width; must equal the element width of y and z
// - Y_N      6  number of y elements (indices 2..Y_N+1)
// - Z_OUTER  6  z outer dimension (indices Z_OUTER+1 downto 2)
// - Z_INNER  8  z middle dimension (indices 2..Z_INNER+1)
// PORTS
// - clk        in   1    clock
// - rst        in   1    synchronous, active-high reset
// - in_valid   in   1    beat valid
// - in_ready   out  1    beat accepted when in_valid && in_ready
// - in_sof     in   1    first beat of a frame; qualified by in_valid
// - in_data    in   4    beat payload
// - out_valid  out  1    s_out holds a complete frame
// - out_ready  in   1    consumer takes s_out when out_valid && out_ready
// - s_out      out  221  frame_t, packed struct from frame_pkg
// - frame_err  out  1    one-cycle pulse: frame aborted
// BEHAVIOUR
// - Reset: all outputs go to 0 except in_ready, which is 1.
//   - FSM returns to IDLE, beat counter to 0, both buffers cleared.
// - Beat order, NUM_BEATS = 2 + Y_N + Z_OUTER*Z_INNER (56 at default):
//   - beat 0: t = in_data[0]; in_data[3:1] is pad and is ignored.
//   - beat 1: x[5:2] = in_data.
//   - beats 2..7: y[2], y[3], ..., y[7], leftmost index first.
//   - beats 8..55: z[7][2], z[7][3], ..., z[7][9], z[6][2], ..., z[2][9].
//   - Within each beat, in_data[3] lands on the element's left index ($left) of its last dimension.
// - FSM states:
//   - IDLE: waits for an accepted beat with in_sof=1, which loads beat 0 and goes to COLLECT.
//     - Beats without in_sof are accepted and dropped; frame_err does not pulse.
//   - COLLECT: each accepted beat with in_sof=0 stores at the counter position and increments the counter.
//     - When the beat at index NUM_BEATS-1 is accepted, go to FULL.
//   - FULL: the assembly buffer is complete.
//     - Copy to the output register when out_valid=0, or when out_valid && out_ready in the same cycle.
//     - After the copy, go to IDLE.
// - in_ready = (state != FULL). Only the beat completing a frame can stall the next frame.
// - Latency: last beat accepted in cycle N -> out_valid=1 in N+2 if the output register is free.
//   - FULL exists for exactly one cycle in that case.
// - out_valid:
//   - set by the copy into the output register;
//   - cleared by out_valid && out_ready with no simultaneous copy;
//   - held at 1 when a copy and a handshake coincide.
// - s_out is stable while out_valid && !out_ready.
// - Abort: an accepted beat with in_sof=1 while in COLLECT.
//   - frame_err pulses for one cycle.
//   - The partial frame is discarded.
//   - The beat restarts a new frame as beat 0; the counter becomes 1.
// - Counter: width $clog2(NUM_BEATS); it never wraps, because it reloads on sof and clears on entry to IDLE.
// - Reset mid-frame or mid-stall: the frame is lost and no frame_err is raised.
// - A pending output is dropped on reset.
// - The assembly buffer is not cleared between frames; every bit is rewritten before the next copy.
// STRUCTURE
// - frame_pkg holds:
//   - typedef sy_t: packed struct, logic [2:7][3:0] y;
//   - typedef sz_t: packed union, z[7:2][2:9][1:4] / z2[1:192];
//   - typedef frame_t: packed struct {t, x[5:2], sy_t sy, sz_t sz};
//   - localparams NUM_BEATS, FRAME_W = $bits(frame_t);
//   - FSM state enum {IDLE, COLLECT, FULL}.
// - One sub-module, frame_beat_decoder, maps the beat counter to a field and index.
//   - Outputs: one-hot select {t, x, y, z}, y index, z outer/inner indices.
// - The top holds the FSM, counter, assembly buffer and output register.
// TESTING
// - Send 56 beats, sof on beat 0, in_data = beat_index[3:0], out_ready=1.
//   - out_valid 2 cycles after the last beat; t=0, x=4'h1, y[2]=4'h2, y[7]=4'h7.
//   - z[7][2]=4'h8, z[2][9]=4'h7 (beat 55).
//   - $bits(s_out)=221.
// - Hold out_ready=0 and send two back-to-back frames A and B.
//   - s_out=A stays stable; in_ready=0 after B's last beat.
//   - Raise out_ready: A is taken, the next cycle s_out=B, and in_ready returns to 1.
// - Send sof at beat 20, then 56 clean beats.
//   - frame_err pulses once in that cycle.
//   - Exactly one frame is output, and it carries the second frame's data.
// - Send 10 beats with in_sof=0 from reset, then a valid frame.
//   - No frame_err; one frame is output and it is correct.
// - Assert rst at beat 30 and again during a FULL stall.
//   - Next cycle: out_valid=0, in_ready=1, frame_err=0.
//   - A following frame decodes correctly.
// - Random in_valid/out_ready gaps over 200 frames, checked against a scoreboard.
//   - s_out.sz.z2 equals the concatenation of beats 8..55.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types for the nibble deframer: the packed frame layout, its derived
// sizes and the deframer FSM state.
package frame_pkg;

  // Frame geometry; the frame type below is built from these, so they live here
  // rather than as module parameters.
  localparam int NIB_W   = 4;
  localparam int Y_N     = 6;
  localparam int Z_OUTER = 6;
  localparam int Z_INNER = 8;

  localparam int NUM_BEATS = 2 + Y_N + Z_OUTER * Z_INNER;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int Z_BASE    = 2 + Y_N;
  localparam int Y_IDX_W   = $clog2(Y_N + 2);
  localparam int ZO_W      = $clog2(Z_OUTER + 2);
  localparam int ZI_W      = $clog2(Z_INNER + 2);
  localparam int Z2_W      = Z_OUTER * Z_INNER * NIB_W;

  typedef struct packed {
    logic [2:Y_N+1][NIB_W-1:0] y;
  } sy_t;

  typedef union packed {
    logic [Z_OUTER+1:2][2:Z_INNER+1][1:NIB_W] z;
    logic [1:Z2_W]                              z2;
  } sz_t;

  typedef struct packed {
    logic       t;
    logic [5:2] x;
    sy_t        sy;
    sz_t        sz;
  } frame_t;

  localparam int FRAME_W = $bits(frame_t);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } state_t;

  // One-hot field select produced by the beat decoder.
  typedef struct packed {
    logic t;
    logic x;
    logic y;
    logic z;
  } beat_sel_t;

endpackage

// File: rtl/frame_beat_decoder.sv
// Maps a beat position within a frame to the field it fills and the element
// index inside that field.
module frame_beat_decoder
  import frame_pkg::*;
(
  input  logic [CNT_W-1:0]   cnt,
  output beat_sel_t          sel,
  output logic [Y_IDX_W-1:0] y_idx,
  output logic [ZO_W-1:0]    z_outer,
  output logic [ZI_W-1:0]    z_inner
);

  int beat;
  int zj;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    sel     = '0;
    y_idx   = '0;
    z_outer = '0;
    z_inner = '0;
    beat    = int'(cnt);
    zj      = beat - Z_BASE;

    if (beat == 0) begin
      sel.t = 1'b1;
    end else if (beat == 1) begin
      sel.x = 1'b1;
    end else if (beat < Z_BASE) begin
      // y indices start at 2, which is exactly the beat number
      sel.y = 1'b1;
      y_idx = Y_IDX_W'(beat);
    end else if (beat < NUM_BEATS) begin
      // z walks the outer index downwards and the inner index upwards
      sel.z   = 1'b1;
      z_outer = ZO_W'(Z_OUTER + 1 - zj / Z_INNER);
      z_inner = ZI_W'(2 + zj % Z_INNER);
    end
  end

endmodule

// File: rtl/struct_nibble_deframer.sv
// Reassembles frame_t from a 4-bit beat stream; one frame assembles while the
// previous one waits in the output register for its consumer.
module struct_nibble_deframer
  import frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [NIB_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output frame_t           s_out,
  output logic             frame_err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  frame_t             build_q;
  frame_t             out_q;
  logic               out_valid_q;
  logic               frame_err_q;

  logic               beat_acc;
  logic               last_beat;
  logic               do_start;
  logic               do_abort;
  logic               do_store;
  logic               do_copy;

  beat_sel_t          sel;
  logic [Y_IDX_W-1:0] y_idx;
  logic [ZO_W-1:0]    z_outer;
  logic [ZI_W-1:0]    z_inner;

  frame_beat_decoder u_decoder (
    .cnt     (cnt_q),
    .sel     (sel),
    .y_idx   (y_idx),
    .z_outer (z_outer),
    .z_inner (z_inner)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q != FULL);
    beat_acc  = in_valid && in_ready;
    last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));
    do_start  = 1'b0;
    do_abort  = 1'b0;
    do_store  = 1'b0;
    do_copy   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // beats arriving without a start marker are silently dropped
        if (beat_acc && in_sof) begin
          do_start = 1'b1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (beat_acc) begin
          if (in_sof) begin
            do_start = 1'b1;
            do_abort = 1'b1;
          end else begin
            do_store = 1'b1;
            if (last_beat) state_d = FULL;
          end
        end
      end
      FULL: begin
        if (!out_valid_q || out_ready) begin
          do_copy = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both frame buffers are cleared so s_out reads zero out of reset;
      // between frames the assembly buffer is fully rewritten and never cleared.
      cnt_q       <= '0;
      build_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= do_abort;

      if (do_start) begin
        build_q.t <= in_data[0];
        cnt_q     <= CNT_W'(1);
      end else if (do_store) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (sel.t)      build_q.t                    <= in_data[0];
        else if (sel.x) build_q.x                    <= in_data;
        else if (sel.y) build_q.sy.y[y_idx]          <= in_data;
        else if (sel.z) build_q.sz.z[z_outer][z_inner] <= in_data;
      end

      if (do_copy) begin
        out_q <= build_q;
        cnt_q <= '0;
      end

      // a copy coinciding with a handshake keeps out_valid high
      if (do_copy)        out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign s_out     = out_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_struct_nibble_deframer.sv
// Directed and randomised-gap bench for struct_nibble_deframer; expected frames
// come from a bit-concatenation model of the beat stream.
module tb_struct_nibble_deframer;
  import frame_pkg::*;

  typedef logic [NIB_W-1:0] beats_t [NUM_BEATS];

  localparam int BEAT_BUDGET  = 500;
  localparam int FRAME_BUDGET = 400;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_sof    = 1'b0;
  logic [NIB_W-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             frame_err;
  logic [220:0]     s_out_bits;

  int errors     = 0;
  int checks     = 0;
  int err_pulses = 0;
  logic [FRAME_W-1:0] got_q[$];

  struct_nibble_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out_bits),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the monitor samples 2 time units later.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(s_out_bits);
      if (frame_err) err_pulses++;
    end
  end

  // Frame bits are the beats concatenated in arrival order (beat 0 gives one bit).
  function automatic logic [FRAME_W-1:0] model(input beats_t b);
    logic [FRAME_W-1:0] v;
    v = '0;
    v[FRAME_W-1] = b[0][0];
    for (int i = 1; i < NUM_BEATS; i++) v[FRAME_W-2-NIB_W*(i-1) -: NIB_W] = b[i];
    return v;
  endfunction

  function automatic logic [Z2_W-1:0] z2_model(input beats_t b);
    logic [Z2_W-1:0] e;
    e = '0;
    for (int i = Z_BASE; i < NUM_BEATS; i++) e = {e[Z2_W-NIB_W-1:0], b[i]};
    return e;
  endfunction

  task automatic make_beats(input int mul, input int add, output beats_t b);
    for (int i = 0; i < NUM_BEATS; i++) b[i] = NIB_W'(i * mul + add);
  endtask

  task automatic send_beat(input logic sof, input logic [NIB_W-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    for (int k = 0; k < BEAT_BUDGET && !done; k++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic send_frame(input beats_t b, input int count, input int gap_max);
    for (int i = 0; i < count; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(i == 0, b[i]);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int k = 0; k < FRAME_BUDGET && got_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_frames(input string name, input beats_t b);
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL %s_count got=%0d required=1", name, got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== model(b)) begin
        errors++;
        $display("FAIL %s_data got=%h required=%h", name, got_q[0], model(b));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b required=0", frame_err); end
    if (s_out_bits !== '0) begin errors++; $display("FAIL reset_s_out got=%h required=0", s_out_bits); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    beats_t b;
    frame_t fr;
    make_beats(1, 0, b);
    got_q.delete();
    out_ready = 1'b1;
    send_frame(b, NUM_BEATS, 0);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_n1 out_valid=%b required=0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_full_stall in_ready=%b required=0", in_ready); end
    @(negedge clk);
    fr = frame_t'(s_out_bits);
    checks += 9;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_n2 out_valid=%b required=1", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back in_ready=%b required=1", in_ready); end
    if (fr.t !== 1'b0) begin errors++; $display("FAIL basic_t got=%h required=0", fr.t); end
    if (fr.x !== 4'h1) begin errors++; $display("FAIL basic_x got=%h required=1", fr.x); end
    if (fr.sy.y[2] !== 4'h2) begin errors++; $display("FAIL basic_y2 got=%h required=2", fr.sy.y[2]); end
    if (fr.sy.y[7] !== 4'h7) begin errors++; $display("FAIL basic_y7 got=%h required=7", fr.sy.y[7]); end
    if (fr.sz.z[7][2] !== 4'h8) begin errors++; $display("FAIL basic_z72 got=%h required=8", fr.sz.z[7][2]); end
    if (fr.sz.z[2][9] !== 4'h7) begin errors++; $display("FAIL basic_z29 got=%h required=7", fr.sz.z[2][9]); end
    if (fr.sz.z2 !== z2_model(b)) begin errors++; $display("FAIL basic_z2 got=%h required=%h", fr.sz.z2, z2_model(b)); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain out_valid=%b required=0", out_valid); end
    check_frames("basic", b);
  endtask

  task automatic test_back_to_back();
    beats_t a, bb;
    bit stable;
    make_beats(3, 1, a);
    make_beats(7, 9, bb);
    got_q.delete();
    out_ready = 1'b0;
    send_frame(a, NUM_BEATS, 0);
    send_frame(bb, NUM_BEATS, 0);
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (s_out_bits !== model(a) || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL b2b_hold s_out=%h in_ready=%b out_valid=%b required s_out=%h in_ready=0 out_valid=1",
               s_out_bits, in_ready, out_valid, model(a));
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held got=%b required=1", out_valid); end
    if (s_out_bits !== model(bb)) begin errors++; $display("FAIL b2b_s_out_b got=%h required=%h", s_out_bits, model(bb)); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%b required=1", in_ready); end
    @(negedge clk);
    checks += 2;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=2", got_q.size());
    end else if (got_q[0] !== model(a) || got_q[1] !== model(bb)) begin
      errors++;
      $display("FAIL b2b_order got0=%h got1=%h", got_q[0], got_q[1]);
    end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid=%b required=0", out_valid); end
  endtask

  task automatic test_abort();
    beats_t c, d;
    int e0;
    make_beats(5, 2, c);
    make_beats(11, 13, d);
    got_q.delete();
    out_ready = 1'b1;
    e0 = err_pulses;
    send_frame(c, 20, 0);
    send_frame(d, NUM_BEATS, 0);
    wait_frames(1);
    repeat (3) @(negedge clk);
    checks++;
    if (err_pulses - e0 !== 1) begin errors++; $display("FAIL abort_err_pulses got=%0d required=1", err_pulses - e0); end
    check_frames("abort", d);
  endtask

  task automatic test_idle_junk();
    beats_t e;
    int e0;
    do_reset();
    make_beats(9, 4, e);
    got_q.delete();
    out_ready = 1'b1;
    e0 = err_pulses;
    for (int i = 0; i < 10; i++) send_beat(1'b0, NIB_W'(15 - i));
    send_frame(e, NUM_BEATS, 0);
    wait_frames(1);
    repeat (3) @(negedge clk);
    checks++;
    if (err_pulses !== e0) begin errors++; $display("FAIL junk_err_pulses got=%0d required=0", err_pulses - e0); end
    check_frames("junk", e);
  endtask

  task automatic reset_pulse_check(input string name);
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got=%b required=0", name, out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got=%b required=1", name, in_ready); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL %s_frame_err got=%b required=0", name, frame_err); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    beats_t f, g, h;
    int e0;
    make_beats(13, 6, f);
    make_beats(2, 15, g);
    make_beats(6, 3, h);
    e0 = err_pulses;
    got_q.delete();
    out_ready = 1'b1;
    send_frame(f, 30, 0);
    reset_pulse_check("rst_mid");
    send_frame(g, NUM_BEATS, 0);
    wait_frames(1);
    repeat (2) @(negedge clk);
    check_frames("rst_mid", g);

    got_q.delete();
    out_ready = 1'b0;
    send_frame(f, NUM_BEATS, 0);
    send_frame(g, NUM_BEATS, 0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_setup in_ready=%b out_valid=%b required 0 and 1", in_ready, out_valid);
    end
    reset_pulse_check("rst_stall");
    out_ready = 1'b1;
    send_frame(h, NUM_BEATS, 0);
    wait_frames(1);
    repeat (3) @(negedge clk);
    check_frames("rst_stall", h);
    checks++;
    if (err_pulses !== e0) begin errors++; $display("FAIL rst_err_pulses got=%0d required=0", err_pulses - e0); end
  endtask

  task automatic test_random();
    beats_t b;
    logic [FRAME_W-1:0] exp_q[$];
    logic [Z2_W-1:0]    z2_q[$];
    frame_t fr;
    bit prod_done;
    int bad;
    prod_done = 1'b0;
    got_q.delete();
    fork
      begin
        for (int f = 0; f < 200; f++) begin
          for (int i = 0; i < NUM_BEATS; i++) b[i] = NIB_W'($urandom);
          exp_q.push_back(model(b));
          z2_q.push_back(z2_model(b));
          send_frame(b, NUM_BEATS, 2);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_frames(200);
    checks++;
    if (got_q.size() !== 200) begin errors++; $display("FAIL rand_count got=%0d required=200", got_q.size()); end
    bad = 0;
    for (int k = 0; k < got_q.size() && k < 200; k++) begin
      fr = frame_t'(got_q[k]);
      checks += 2;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        if (bad++ < 4) $display("FAIL rand_frame_%0d got=%h required=%h", k, got_q[k], exp_q[k]);
      end
      if (fr.sz.z2 !== z2_q[k]) begin
        errors++;
        if (bad++ < 4) $display("FAIL rand_z2_%0d got=%h required=%h", k, fr.sz.z2, z2_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_idle_junk();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
